// File: rtl/alu_16.sv
// 16-bit registered ALU: ADD/SUB with carry/borrow, AND/OR/XOR, and an error
// marker for unused opcodes. One output register stage, asynchronous active-low reset.
module alu_16 (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] operand_a,
    input  logic [15:0] operand_b,
    input  logic [3:0]  opcode,
    input  logic        carry_in,
    output logic [15:0] result,
    output logic        carry_out
);

    typedef enum logic [3:0] {
        OP_ADD = 4'b0000,
        OP_SUB = 4'b0001,
        OP_AND = 4'b0101,
        OP_OR  = 4'b0110,
        OP_XOR = 4'b0111
    } op_t;

    localparam logic [15:0] ERROR_MARKER = 16'hBAD1;

    logic [16:0] wide_a;
    logic [16:0] wide_b;
    logic [16:0] wide_cin;
    logic [15:0] next_result;
    logic        next_carry;

    assign wide_a   = {1'b0, operand_a};
    assign wide_b   = {1'b0, operand_b};
    assign wide_cin = {16'h0000, carry_in};

    // Arithmetic runs at 17 bits so bit 16 is the carry (ADD) or borrow (SUB).
    always_comb begin
        next_result = ERROR_MARKER;
        next_carry  = 1'b0;
        case (opcode)
            OP_ADD: {next_carry, next_result} = wide_a + wide_b + wide_cin;
            OP_SUB: {next_carry, next_result} = wide_a - wide_b - wide_cin;
            OP_AND: next_result = operand_a & operand_b;
            OP_OR:  next_result = operand_a | operand_b;
            OP_XOR: next_result = operand_a ^ operand_b;
            default: begin
                next_result = ERROR_MARKER;
                next_carry  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result    <= 16'h0000;
            carry_out <= 1'b0;
        end else begin
            result    <= next_result;
            carry_out <= next_carry;
        end
    end

endmodule

// File: tb/tb_alu_16.sv
// Directed self-checking bench for alu_16: reset, each opcode class,
// back-to-back issue and an asynchronous reset pulse between clock edges.
module tb_alu_16;

    logic        clk;
    logic        reset;
    logic [15:0] operand_a;
    logic [15:0] operand_b;
    logic [3:0]  opcode;
    logic        carry_in;
    logic [15:0] result;
    logic        carry_out;

    int errors = 0;
    int checks = 0;

    alu_16 dut (
        .clk       (clk),
        .reset     (reset),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .opcode    (opcode),
        .carry_in  (carry_in),
        .result    (result),
        .carry_out (carry_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic cin);
        opcode    = op;
        operand_a = a;
        operand_b = b;
        carry_in  = cin;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        drive(4'b0000, 16'h1234, 16'h5678, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({carry_out, result} !== 17'h00000) begin
                errors++;
                $display("[TB] FAIL reset_hold[%0d]: got cout=%b result=%h, want cout=0 result=0000",
                         i, carry_out, result);
            end
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({carry_out, result} !== {1'b0, 16'h68AC}) begin
            errors++;
            $display("[TB] FAIL reset_release: got cout=%b result=%h, want cout=0 result=68ac",
                     carry_out, result);
        end
    endtask

    // Each row: opcode, a, b, cin, expected {cout, result}
    task automatic run_table(input string name, input logic [3:0] ops [],
                             input logic [15:0] as [], input logic [15:0] bs [],
                             input logic cins [], input logic [16:0] exps []);
        for (int i = 0; i < ops.size(); i++) begin
            @(negedge clk);
            drive(ops[i], as[i], bs[i], cins[i]);
            @(posedge clk);
            #1;
            checks++;
            if ({carry_out, result} !== exps[i]) begin
                errors++;
                $display("[TB] FAIL %s[%0d]: got cout=%b result=%h, want cout=%b result=%h",
                         name, i, carry_out, result, exps[i][16], exps[i][15:0]);
            end
        end
    endtask

    task automatic test_add;
        logic [3:0]  ops  [] = '{4'b0000, 4'b0000, 4'b0000};
        logic [15:0] as   [] = '{16'h0005, 16'hFFFF, 16'hFFFF};
        logic [15:0] bs   [] = '{16'h0003, 16'h0001, 16'hFFFF};
        logic        cins [] = '{1'b0, 1'b0, 1'b1};
        logic [16:0] exps [] = '{17'h00008, 17'h10000, 17'h1FFFF};
        run_table("add", ops, as, bs, cins, exps);
    endtask

    task automatic test_sub;
        logic [3:0]  ops  [] = '{4'b0001, 4'b0001, 4'b0001};
        logic [15:0] as   [] = '{16'h0005, 16'h0000, 16'h0003};
        logic [15:0] bs   [] = '{16'h0003, 16'h0001, 16'h0003};
        logic        cins [] = '{1'b1, 1'b0, 1'b1};
        logic [16:0] exps [] = '{17'h00001, 17'h1FFFF, 17'h1FFFF};
        run_table("sub", ops, as, bs, cins, exps);
    endtask

    task automatic test_logic;
        logic [3:0]  ops  [] = '{4'b0101, 4'b0110, 4'b0111};
        logic [15:0] as   [] = '{16'h00FF, 16'h00FF, 16'h00FF};
        logic [15:0] bs   [] = '{16'h0F0F, 16'h0F0F, 16'h0F0F};
        logic        cins [] = '{1'b1, 1'b1, 1'b1};
        logic [16:0] exps [] = '{17'h0000F, 17'h00FFF, 17'h00FF0};
        run_table("logic", ops, as, bs, cins, exps);
    endtask

    task automatic test_undefined;
        logic [3:0]  ops  [] = '{4'b0011, 4'b1111, 4'b0010, 4'b0100, 4'b1000};
        logic [15:0] as   [] = '{16'hFFFF, 16'h1234, 16'h0001, 16'hFFFF, 16'h8000};
        logic [15:0] bs   [] = '{16'hFFFF, 16'h4321, 16'h0001, 16'h0000, 16'h8000};
        logic        cins [] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [16:0] exps [] = '{17'h0BAD1, 17'h0BAD1, 17'h0BAD1, 17'h0BAD1, 17'h0BAD1};
        run_table("undef", ops, as, bs, cins, exps);
    endtask

    // New inputs are applied right after each edge; the old result must hold
    // until the next edge, then the new one must appear.
    task automatic test_back_to_back;
        logic [3:0]  ops  [4] = '{4'b0000, 4'b0001, 4'b0101, 4'b0111};
        logic [15:0] as   [4] = '{16'h1234, 16'h1000, 16'hF0F0, 16'hAAAA};
        logic [15:0] bs   [4] = '{16'h1111, 16'h0001, 16'hFF00, 16'h5555};
        logic        cins [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic [16:0] exps [4] = '{17'h02346, 17'h00FFF, 17'h0F000, 17'h0FFFF};
        @(negedge clk);
        drive(ops[0], as[0], bs[0], cins[0]);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({carry_out, result} !== exps[i]) begin
                errors++;
                $display("[TB] FAIL b2b[%0d]: got cout=%b result=%h, want cout=%b result=%h",
                         i, carry_out, result, exps[i][16], exps[i][15:0]);
            end
            if (i < 3) begin
                drive(ops[i+1], as[i+1], bs[i+1], cins[i+1]);
                #3;
                checks++;
                if ({carry_out, result} !== exps[i]) begin
                    errors++;
                    $display("[TB] FAIL b2b_hold[%0d]: got cout=%b result=%h, want cout=%b result=%h",
                             i, carry_out, result, exps[i][16], exps[i][15:0]);
                end
            end
        end
    endtask

    task automatic test_async_reset;
        @(negedge clk);
        drive(4'b0000, 16'hFFFF, 16'h0003, 1'b0);
        @(posedge clk);
        #1;
        checks++;
        if ({carry_out, result} !== 17'h10002) begin
            errors++;
            $display("[TB] FAIL pre_pulse: got cout=%b result=%h, want cout=1 result=0002",
                     carry_out, result);
        end
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if ({carry_out, result} !== 17'h00000) begin
            errors++;
            $display("[TB] FAIL async_assert: got cout=%b result=%h, want cout=0 result=0000",
                     carry_out, result);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({carry_out, result} !== 17'h00000) begin
            errors++;
            $display("[TB] FAIL async_released_hold: got cout=%b result=%h, want cout=0 result=0000",
                     carry_out, result);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({carry_out, result} !== 17'h10002) begin
            errors++;
            $display("[TB] FAIL async_recover: got cout=%b result=%h, want cout=1 result=0002",
                     carry_out, result);
        end
    endtask

    initial begin
        reset = 1'b0;
        drive(4'b0000, 16'h0000, 16'h0000, 1'b0);
        #1;
        checks++;
        if ({carry_out, result} !== 17'h00000) begin
            errors++;
            $display("[TB] FAIL reset_initial: got cout=%b result=%h, want cout=0 result=0000",
                     carry_out, result);
        end
        test_reset();
        test_add();
        test_sub();
        test_logic();
        test_undefined();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
